reg_file_sorter: RTL
====================

Name: reg_file_sorter

Overview:
- Register file of 2**N words with a built-in bubble-sort engine.
- The engine initiates its own read-A / read-B / write-A / write-B swap sequences over the array until it is in ascending unsigned order.
- Host loads data through a write port, pulses start, waits for done, then reads the results back.
- Sits beside the existing swap datapath as the block that decides which swaps to issue, instead of receiving swap commands.

Parameters:
- N, 3, address width; depth M = 2**N; N >= 1.
- BITS, 8, data word width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  sort request; sampled only in IDLE.
- w_en  input  1  host write enable; honoured only in IDLE.
- w_addr  input  N  host write address.
- w_data  input  BITS  host write data.
- r_addr  input  N  host read address.
- r_data  output  BITS  combinational mem[r_addr], valid in every state.
- busy  output  1  high while sorting; low in IDLE and DONE.
- done  output  1  one-cycle pulse when the sort completes.
- swap_cnt  output  2N  number of swaps performed by the last or current sort.

Behaviour:
- Reset (rstn low, asynchronous):
  - All M words cleared to 0.
  - State goes to IDLE; busy=0, done=0, swap_cnt=0.
  - Internal idx, limit, tmp_a, tmp_b and the swapped flag are cleared.
  - Reset mid-sort aborts the sort with no partial result kept.
- States: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE. One memory access per cycle.
- IDLE:
  - w_en=1 writes mem[w_addr]<=w_data at the edge.
  - start=1 sets idx=0, limit=M-1, swapped=0, swap_cnt=0, and goes to RD_A.
  - If w_en and start are high in the same cycle, the write lands first and the sort sees the new data.
- RD_A: tmp_a<=mem[idx]; go to RD_B.
- RD_B: tmp_b<=mem[idx+1]; go to CMP.
- CMP:
  - If tmp_a > tmp_b (unsigned): go to WR_A.
  - Otherwise advance (see below).
- WR_A: mem[idx]<=tmp_b; go to WR_B.
- WR_B: mem[idx+1]<=tmp_a; swap_cnt+1; swapped<=1; advance.
- Advance:
  - If idx+1 < limit: idx+1, go to RD_A.
  - Otherwise (end of pass):
    - If swapped=0 or limit=1: go to DONE.
    - Else: limit-1, idx=0, swapped=0, go to RD_A.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Equal values are never swapped, so the sort is stable and does no extra writes.
- Cycle cost: a compare without swap takes 3 cycles; a compare with swap takes 5 cycles; DONE adds 1.
- While busy, w_en and start are ignored. r_data still reflects the live array, including intermediate values.
- swap_cnt holds its value after DONE until the next accepted start. Maximum M(M-1)/2 < 2**(2N), so no overflow.
- The address idx+1 never exceeds M-1.

Test Plan:
- Reset values: assert rstn=0 mid-operation → r_data=0 at every address, busy=0, done=0, swap_cnt=0.
- Already sorted (N=3, BITS=8), values 0..7 at addresses 0..7, then start:
  - busy high for 21 cycles (7 compares × 3).
  - done in the 22nd cycle after the start edge.
  - swap_cnt=0; array unchanged.
- Reverse order, values 7..0, then start:
  - Array becomes 0..7.
  - swap_cnt=28.
  - done in the 141st cycle after the start edge (28 × 5 + 1).
- Duplicates, values {5,3,5,1,3,0,5,2}:
  - Result {0,1,2,3,3,5,5,5}.
  - swap_cnt=16 (equal to the inversion count).
- Busy interlock:
  - w_en=1 to addr 0 with 8'hFF during a sort → ignored.
  - A second start pulse during the sort → ignored.
  - Exactly one done pulse.
  - A write of 8'hFF to addr 0 applied together with start in IDLE → sorted in, ends at addr 7.
- Reset mid-sort at cycle 10 of the reverse-order case → array all 0, IDLE, no done pulse.
- A later start sorts the zero array with swap_cnt=0.

Source files
------------

// File: rtl/reg_file_sorter_if.sv
// -----------------------------------------------------------------------------
// reg_file_sorter_if
// Host-side bus of the sorting register file.
//   start    : sort request (sampled only while the sorter is idle)
//   w_en     : host write enable (honoured only while idle)
//   w_addr   : host write address
//   w_data   : host write data
//   r_addr   : host read address
//   r_data   : combinational read data, mem[r_addr]
//   busy     : high while a sort is running
//   done     : one-cycle pulse when a sort completes
//   swap_cnt : swaps performed by the last or current sort
// Modports: master = host side, slave = sorter side.
// -----------------------------------------------------------------------------
interface reg_file_sorter_if #(
    parameter int N    = 3,
    parameter int BITS = 8
);
    logic            start;
    logic            w_en;
    logic [N-1:0]    w_addr;
    logic [BITS-1:0] w_data;
    logic [N-1:0]    r_addr;
    logic [BITS-1:0] r_data;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  swap_cnt;

    modport master (
        output start, w_en, w_addr, w_data, r_addr,
        input  r_data, busy, done, swap_cnt
    );

    modport slave (
        input  start, w_en, w_addr, w_data, r_addr,
        output r_data, busy, done, swap_cnt
    );
endinterface

// File: rtl/reg_file_sorter.sv
// -----------------------------------------------------------------------------
// reg_file_sorter
// Register file of 2**N words with a built-in bubble-sort engine. The host
// loads words while idle, pulses start, waits for done and reads the array
// back, now in ascending unsigned order. The engine issues its own
// read-A / read-B / write-A / write-B swap sequences, one memory access per
// cycle.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset (clears array and engine state)
//   host : reg_file_sorter_if.slave (start, write port, read port, status)
// -----------------------------------------------------------------------------
module reg_file_sorter #(
    parameter int N    = 3,
    parameter int BITS = 8
) (
    input  logic               clk,
    input  logic               rstn,
    reg_file_sorter_if.slave   host
);
    localparam int M = 2**N;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic [N-1:0]    r_idx, w_idx_next;
    logic [N-1:0]    r_limit, w_limit_next;
    logic [BITS-1:0] r_tmp_a, w_tmp_a_next;
    logic [BITS-1:0] r_tmp_b, w_tmp_b_next;
    logic            r_swapped, w_swapped_next;
    logic [2*N-1:0]  r_swap_cnt, w_swap_cnt_next;

    logic [BITS-1:0] w_words [M];
    logic            w_wr_en;
    logic [N-1:0]    w_wr_addr;
    logic [BITS-1:0] w_wr_data;

    logic [N-1:0]    w_idx_p1;
    logic            w_more;
    logic            w_advance;

    // idx+1 never exceeds limit (<= M-1), so the N-bit increment cannot wrap
    // on any path where it is used as an address.
    assign w_idx_p1 = r_idx + N'(1);
    assign w_more   = ({1'b0, r_idx} + (N+1)'(1)) < {1'b0, r_limit};

    // Single write port shared by the host (idle only) and the swap writes.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = host.w_addr;
        w_wr_data = host.w_data;
        case (r_state)
            S_IDLE: w_wr_en = host.w_en;
            S_WR_A: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_idx;
                w_wr_data = r_tmp_b;
            end
            S_WR_B: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_idx_p1;
                w_wr_data = r_tmp_a;
            end
            default: ;
        endcase
    end

    // One register per word; the array must be reset and read
    // combinationally, so it is built from flops rather than RAM.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_word
            logic [BITS-1:0] r_word;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    r_word <= '0;
                else if (w_wr_en && (w_wr_addr == N'(gi)))
                    r_word <= w_wr_data;
            end
            assign w_words[gi] = r_word;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_limit    <= '0;
            r_tmp_a    <= '0;
            r_tmp_b    <= '0;
            r_swapped  <= 1'b0;
            r_swap_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_limit    <= w_limit_next;
            r_tmp_a    <= w_tmp_a_next;
            r_tmp_b    <= w_tmp_b_next;
            r_swapped  <= w_swapped_next;
            r_swap_cnt <= w_swap_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_limit_next    = r_limit;
        w_tmp_a_next    = r_tmp_a;
        w_tmp_b_next    = r_tmp_b;
        w_swapped_next  = r_swapped;
        w_swap_cnt_next = r_swap_cnt;
        w_advance       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (host.start) begin
                    w_state_next    = S_RD_A;
                    w_idx_next      = '0;
                    w_limit_next    = '1;   // M-1
                    w_swapped_next  = 1'b0;
                    w_swap_cnt_next = '0;
                end
            end
            S_RD_A: begin
                w_tmp_a_next = w_words[r_idx];
                w_state_next = S_RD_B;
            end
            S_RD_B: begin
                w_tmp_b_next = w_words[w_idx_p1];
                w_state_next = S_CMP;
            end
            S_CMP: begin
                // Strict compare: equal words stay put, keeping the sort stable.
                if (r_tmp_a > r_tmp_b)
                    w_state_next = S_WR_A;
                else
                    w_advance = 1'b1;
            end
            S_WR_A: w_state_next = S_WR_B;
            S_WR_B: begin
                w_swap_cnt_next = r_swap_cnt + (2*N)'(1);
                w_swapped_next  = 1'b1;
                w_advance       = 1'b1;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // End-of-pass test uses the swapped flag including a swap made this
        // very cycle in WR_B.
        if (w_advance) begin
            if (w_more) begin
                w_idx_next   = w_idx_p1;
                w_state_next = S_RD_A;
            end else if (!w_swapped_next || (r_limit == N'(1))) begin
                w_state_next = S_DONE;
            end else begin
                w_limit_next   = r_limit - N'(1);
                w_idx_next     = '0;
                w_swapped_next = 1'b0;
                w_state_next   = S_RD_A;
            end
        end
    end

    assign host.r_data   = w_words[host.r_addr];
    assign host.busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign host.done     = (r_state == S_DONE);
    assign host.swap_cnt = r_swap_cnt;
endmodule
